fp_addsub_sched: RTL and testbench
==================================

Name: fp_addsub_sched

Overview:
- Round-robin scheduler that shares one combinational FP_AddSub datapath among NUM_REQ requesters.
- Each request carries two operands and an add/sub select. The scheduler grants one request and drives the operands to the datapath from registers. It holds them for OP_LATENCY cycles as a multicycle path, then captures the result and OF/UF flags. The response is returned with the requester ID.
- Sits between the FP_Unit issue logic and the FP_AddSub instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of requester ID; must satisfy 2^ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 64, operand/result width.
- OP_LATENCY, 2, cycles operands are held before result capture (>=1).

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_req_valid  input  NUM_REQ  per-requester request valid.
- in_req_numA  input  NUM_REQ*DATA_WIDTH  operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_req_numB  input  NUM_REQ*DATA_WIDTH  operand B, same packing as in_req_numA.
- in_req_addsub  input  NUM_REQ  0 = add, 1 = subtract.
- out_req_ready  output  NUM_REQ  one-hot grant/accept.
- out_fp_numA  output  DATA_WIDTH  registered operand A to datapath.
- out_fp_numB  output  DATA_WIDTH  registered operand B to datapath.
- out_fp_addsub  output  1  registered op select to datapath.
- in_fp_result  input  DATA_WIDTH  datapath result.
- in_fp_OF  input  1  datapath overflow flag.
- in_fp_UF  input  1  datapath underflow flag.
- out_rsp_valid  output  1  response valid.
- in_rsp_ready  input  1  response consumer ready.
- out_rsp_id  output  ID_WIDTH  index of the requester that issued the op.
- out_rsp_result  output  DATA_WIDTH  captured result.
- out_rsp_OF  output  1  captured overflow flag.
- out_rsp_UF  output  1  captured underflow flag.
- out_busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset: one clock in_clk; reset in_rst_n is asynchronous, active-low. On reset:
  - state = IDLE.
  - All registered outputs are 0.
  - Round-robin pointer = 0, so requester 0 has top priority.
  - Counter = 0.
  - Reset mid-operation discards the in-flight op; no response is produced.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant = first asserted in_req_valid searching from pointer upward, wrapping modulo NUM_REQ.
  - out_req_ready is combinational: the one-hot grant in IDLE, all zeros in every other state.
  - A handshake occurs when valid and ready are both high. On that edge:
    - latch the granted numA/numB/addsub into out_fp_*;
    - latch the grant index into the ID register;
    - pointer = grant index + 1 (mod NUM_REQ);
    - counter = OP_LATENCY - 1;
    - state -> EXEC.
  - No valid: stay in IDLE; out_fp_* hold their last values.
- EXEC:
  - out_fp_* held stable.
  - If counter == 0: capture in_fp_result, in_fp_OF and in_fp_UF into the rsp registers; state -> RESP.
  - Otherwise decrement the counter.
  - EXEC lasts exactly OP_LATENCY cycles.
- RESP:
  - out_rsp_valid = 1; result, flags and ID are stable.
  - On in_rsp_ready = 1 the state goes to IDLE and out_rsp_valid drops on the next cycle.
  - No new grant is issued until the state is back in IDLE.
- Timing: handshake at cycle T gives out_rsp_valid high from cycle T+OP_LATENCY+1. Minimum issue interval is OP_LATENCY+2 cycles.
- Requester rule: in_req_valid and the requester's operands must stay stable until ready is seen. The scheduler samples data only on the handshake edge.
- Simultaneous requests: exactly one grant per IDLE cycle. Strict rotation means every requester is served within NUM_REQ grants.
- out_rsp_id width is ID_WIDTH; unused ID codes are never produced.

Optional Feature:
- Macro: FP_SCHED_STICKY_FLAGS_EN.
- When defined, the block adds:
  - in_sticky_clr, input, NUM_REQ, per-requester sticky clear;
  - out_sticky_OF, output, NUM_REQ, sticky overflow per requester;
  - out_sticky_UF, output, NUM_REQ, sticky underflow per requester.
- Set rule: at result capture, bit[id] of each sticky register is ORed with the captured OF/UF.
- Clear rule: in_sticky_clr[i] clears bit i on the next edge. If set and clear hit the same bit on the same edge, set wins.
- Sticky bits reset to 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single add, OP_LATENCY=2, in_rsp_ready held 1: requester 1 sends A=0x3FF0000000000000, B=0x4000000000000000, addsub=0 -> ready[1] at cycle 0; out_rsp_valid at cycle 3 with result 0x4008000000000000, id=1, OF=UF=0; out_rsp_valid low at cycle 4.
- Subtract: requester 0 sends A=0x4008000000000000, B=0x3FF0000000000000, addsub=1 -> result 0x4000000000000000, id=0.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0; consecutive grants exactly OP_LATENCY+2 cycles apart with in_rsp_ready=1.
- Backpressure: in_rsp_ready=0 for 5 cycles while in RESP -> result, ID and out_rsp_valid held stable; out_req_ready all 0; grant occurs only after RESP exits.
- Reset asserted during EXEC -> all outputs 0 immediately; no response after reset release; next grant goes to requester 0 when multiple requesters are valid.
- With FP_SCHED_STICKY_FLAGS_EN: requester 2 op with datapath OF=1 -> out_sticky_OF[2]=1 persists over later clean ops; in_sticky_clr[2] on the capture edge of another OF op for requester 2 -> bit stays 1.

Source files
------------

// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: round-robin scheduler that shares one combinational FP add/sub
// datapath among NUM_REQ requesters. Operands are held in registers for
// OP_LATENCY cycles (multicycle path), then the result and OF/UF flags are captured
// and returned with the requester ID.
// Optional feature macro: FP_SCHED_STICKY_FLAGS_EN adds per-requester sticky OF/UF.
module fp_addsub_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OP_LATENCY = 2
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic [NUM_REQ-1:0]            in_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_numA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_numB,
  input  logic [NUM_REQ-1:0]            in_req_addsub,
  output logic [NUM_REQ-1:0]            out_req_ready,
  output logic [DATA_WIDTH-1:0]         out_fp_numA,
  output logic [DATA_WIDTH-1:0]         out_fp_numB,
  output logic                          out_fp_addsub,
  input  logic [DATA_WIDTH-1:0]         in_fp_result,
  input  logic                          in_fp_OF,
  input  logic                          in_fp_UF,
  output logic                          out_rsp_valid,
  input  logic                          in_rsp_ready,
  output logic [ID_WIDTH-1:0]           out_rsp_id,
  output logic [DATA_WIDTH-1:0]         out_rsp_result,
  output logic                          out_rsp_OF,
  output logic                          out_rsp_UF,
`ifdef FP_SCHED_STICKY_FLAGS_EN
  input  logic [NUM_REQ-1:0]            in_sticky_clr,
  output logic [NUM_REQ-1:0]            out_sticky_OF,
  output logic [NUM_REQ-1:0]            out_sticky_UF,
`endif
  output logic                          out_busy
);

  localparam int unsigned CNT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [ID_WIDTH-1:0]     ptr_q;
  logic [ID_WIDTH-1:0]     ptr_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [DATA_WIDTH-1:0]   fp_a_q;
  logic [DATA_WIDTH-1:0]   fp_b_q;
  logic                    fp_sub_q;
  logic [DATA_WIDTH-1:0]   rsp_res_q;
  logic                    rsp_of_q;
  logic                    rsp_uf_q;
  logic                    rsp_valid_q;
  logic                    busy_q;

  logic [NUM_REQ-1:0]      rot_valid;
  logic                    gnt_found;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]      gnt_oh;
  logic [DATA_WIDTH-1:0]   gnt_a;
  logic [DATA_WIDTH-1:0]   gnt_b;
  logic                    gnt_sub;
  logic                    capture_c;

  // Round-robin search: rotate valids so the pointer sits at bit 0, take first hit.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rot_valid = NUM_REQ'({in_req_valid, in_req_valid} >> ptr_q);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && rot_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
      end
    end
    ptr_d  = ID_WIDTH'((32'(gnt_idx) + 32'd1) % NUM_REQ);
    gnt_oh = NUM_REQ'(1) << gnt_idx;
  end

  // Operand mux for the granted requester.
  always_comb begin
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_sub = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_WIDTH'(i)) begin
        gnt_a   = in_req_numA[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_b   = in_req_numB[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_sub = in_req_addsub[i];
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is asserted.
  assign out_req_ready = (state_q == S_IDLE && in_rst_n && gnt_found) ? gnt_oh : '0;
  assign capture_c     = (state_q == S_EXEC) && (cnt_q == '0);

  // Scheduler FSM: issue, hold operands for OP_LATENCY cycles, capture, respond.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      fp_a_q      <= '0;
      fp_b_q      <= '0;
      fp_sub_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_of_q    <= 1'b0;
      rsp_uf_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            fp_a_q   <= gnt_a;
            fp_b_q   <= gnt_b;
            fp_sub_q <= gnt_sub;
            id_q     <= gnt_idx;
            ptr_q    <= ptr_d;
            cnt_q    <= CNT_LOAD;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            rsp_res_q   <= in_fp_result;
            rsp_of_q    <= in_fp_OF;
            rsp_uf_q    <= in_fp_UF;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (in_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_fp_numA    = fp_a_q;
  assign out_fp_numB    = fp_b_q;
  assign out_fp_addsub  = fp_sub_q;
  assign out_rsp_valid  = rsp_valid_q;
  assign out_rsp_id     = id_q;
  assign out_rsp_result = rsp_res_q;
  assign out_rsp_OF     = rsp_of_q;
  assign out_rsp_UF     = rsp_uf_q;
  assign out_busy       = busy_q;

`ifdef FP_SCHED_STICKY_FLAGS_EN
  logic [NUM_REQ-1:0] sticky_of_q;
  logic [NUM_REQ-1:0] sticky_uf_q;
  logic [NUM_REQ-1:0] id_oh;

  assign id_oh = NUM_REQ'(1) << id_q;

  // Sticky flags: clear first, then OR in the captured flag so set wins.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sticky_of_q <= '0;
      sticky_uf_q <= '0;
    end else begin
      sticky_of_q <= (sticky_of_q & ~in_sticky_clr) | ((capture_c && in_fp_OF) ? id_oh : '0);
      sticky_uf_q <= (sticky_uf_q & ~in_sticky_clr) | ((capture_c && in_fp_UF) ? id_oh : '0);
    end
  end

  assign out_sticky_OF = sticky_of_q;
  assign out_sticky_UF = sticky_uf_q;
`else
  logic unused_capture;
  assign unused_capture = capture_c;
`endif

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench for fp_addsub_sched: directed steps followed by randomized
// requests, checked against a transaction-level round-robin / datapath model.
module tb_fp_addsub_sched;

  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int OPL = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_v;
  logic [NR*DW-1:0] req_a_flat, req_b_flat;
  logic [NR-1:0]   req_s_flat;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   fp_a, fp_b, fp_res;
  logic            fp_sub, fp_of, fp_uf;
  logic            rsp_valid, rsp_ready, rsp_of, rsp_uf, busy;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_res;
`ifdef FP_SCHED_STICKY_FLAGS_EN
  logic [NR-1:0]   sticky_clr, sticky_of, sticky_uf;
  logic [NR-1:0]   clr_mask;
`endif

  logic [63:0] ra [NR];
  logic [63:0] rb [NR];
  logic        rs [NR];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_gnt = 0;
  int last_bp  = 0;
  bit check_gap = 1'b0;
  int ptr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_addsub_sched #(.NUM_REQ(NR), .ID_WIDTH(2), .DATA_WIDTH(DW), .OP_LATENCY(OPL)) dut (
    .in_clk         (clk),
    .in_rst_n       (rst_n),
    .in_req_valid   (req_v),
    .in_req_numA    (req_a_flat),
    .in_req_numB    (req_b_flat),
    .in_req_addsub  (req_s_flat),
    .out_req_ready  (req_ready),
    .out_fp_numA    (fp_a),
    .out_fp_numB    (fp_b),
    .out_fp_addsub  (fp_sub),
    .in_fp_result   (fp_res),
    .in_fp_OF       (fp_of),
    .in_fp_UF       (fp_uf),
    .out_rsp_valid  (rsp_valid),
    .in_rsp_ready   (rsp_ready),
    .out_rsp_id     (rsp_id),
    .out_rsp_result (rsp_res),
    .out_rsp_OF     (rsp_of),
    .out_rsp_UF     (rsp_uf),
`ifdef FP_SCHED_STICKY_FLAGS_EN
    .in_sticky_clr  (sticky_clr),
    .out_sticky_OF  (sticky_of),
    .out_sticky_UF  (sticky_uf),
`endif
    .out_busy       (busy)
  );

  // Datapath stand-in: real add/sub; OF when both operands negative, UF on exact self-cancel.
  function automatic logic [65:0] dp_ref(input logic [63:0] a, input logic [63:0] b, input logic s);
    real x, y, r;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    r = s ? (x - y) : (x + y);
    return {a[63] & b[63], s & (a == b), $realtobits(r)};
  endfunction

  always_comb {fp_of, fp_uf, fp_res} = dp_ref(fp_a, fp_b, fp_sub);

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_a_flat[i*DW +: DW] = ra[i];
      req_b_flat[i*DW +: DW] = rb[i];
      req_s_flat[i]          = rs[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input real a, input real b, input logic s);
    ra[i] = $realtobits(a);
    rb[i] = $realtobits(b);
    rs[i] = s;
    req_v[i] = 1'b1;
  endtask

  task automatic rand_req(input int i);
    set_req(i, real'(int'($urandom_range(0, 40)) - 20), real'(int'($urandom_range(0, 40)) - 20),
            logic'($urandom_range(0, 1)));
  endtask

  // Next grant by strict rotation from the model pointer.
  function automatic int rr_pick();
    for (int k = 0; k < NR; k++)
      if (req_v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // One full transaction from the IDLE sample point back to IDLE.
  task automatic serve(input int g, input int bp, input bit keep);
    logic [63:0] ea, eb;
    logic        es;
    logic [65:0] er;
    ea = ra[g]; eb = rb[g]; es = rs[g];
    er = dp_ref(ea, eb, es);
    #1;
    chk("grant", 64'(req_ready), 64'(4'b0001 << g));
    if (check_gap) chk("issue_gap", 64'(cyc - last_gnt), 64'(OPL + 2 + last_bp));
    last_gnt = cyc;
    last_bp  = bp;
    tick();
    if (!keep) req_v[g] = 1'b0;
    for (int c = 1; c <= OPL; c++) begin
      chk("exec_ready", 64'(req_ready), 64'(0));
      chk("exec_busy", 64'(busy), 64'(1));
      chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("exec_numA", fp_a, ea);
      chk("exec_numB", fp_b, eb);
      chk("exec_addsub", 64'(fp_sub), 64'(es));
`ifdef FP_SCHED_STICKY_FLAGS_EN
      if (c == OPL) sticky_clr = clr_mask;
`endif
      tick();
`ifdef FP_SCHED_STICKY_FLAGS_EN
      sticky_clr = '0;
`endif
    end
    rsp_ready = (bp == 0);
    for (int c = 0; c <= bp; c++) begin
      if (c == bp) rsp_ready = 1'b1;
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_result", rsp_res, er[63:0]);
      chk("rsp_OF", 64'(rsp_of), 64'(er[65]));
      chk("rsp_UF", 64'(rsp_uf), 64'(er[64]));
      chk("rsp_ready_zero", 64'(req_ready), 64'(0));
      tick();
    end
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    ptr = (g + 1) % NR;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_numA"}, fp_a, 64'(0));
    chk({tag, "_numB"}, fp_b, 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_result"}, rsp_res, 64'(0));
`ifdef FP_SCHED_STICKY_FLAGS_EN
    chk({tag, "_sticky_OF"}, 64'(sticky_of), 64'(0));
    chk({tag, "_sticky_UF"}, 64'(sticky_uf), 64'(0));
`endif
  endtask

  initial begin
    int g;
    int bp;
    int order [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_v = '0;
    for (int i = 0; i < NR; i++) begin ra[i] = '0; rb[i] = '0; rs[i] = 1'b0; end
`ifdef FP_SCHED_STICKY_FLAGS_EN
    sticky_clr = '0;
    clr_mask = '0;
`endif
    tick(); tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single add on requester 1 with rsp_ready held high.
    set_req(1, 1.0, 2.0, 1'b0);
    serve(1, 0, 0);
    chk("add_raw_result", rsp_res, 64'h4008000000000000);

    // Subtract on requester 0 (pointer is now at 2, wraps to 0).
    set_req(0, 3.0, 1.0, 1'b1);
    serve(0, 0, 0);
    chk("sub_raw_result", rsp_res, 64'h4000000000000000);

    // Reset pulse, then all four requesters continuously valid.
    rst_n = 1'b0; tick(); rst_n = 1'b1; ptr = 0;
    for (int i = 0; i < NR; i++) set_req(i, real'(i + 1), real'(2 * i), 1'(i % 2));
    for (int n = 0; n < 5; n++) begin
      check_gap = (n != 0);
      serve(order[n], 0, 1);
    end
    check_gap = 1'b0;
    req_v = '0;

    // Backpressure on RESP with another requester waiting.
    rand_req(0); rand_req(3);
    serve(rr_pick(), 5, 0);
    check_gap = 1'b1;
    serve(rr_pick(), 0, 0);
    check_gap = 1'b0;

    // Randomized back-to-back traffic with occasional backpressure.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++)
        if (!req_v[i] && $urandom_range(0, 1) == 1) rand_req(i);
      if (req_v == '0) rand_req(int'($urandom_range(0, NR - 1)));
      g  = rr_pick();
      bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      serve(g, bp, 0);
    end
    req_v = '0;
    tick();

    // Reset in the middle of EXEC: op discarded, pointer back to 0.
    rand_req(1); rand_req(2);
    #1;
    chk("pre_rst_grant", 64'(req_ready), 64'(4'b0001 << rr_pick()));
    tick();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_exec_reset");
    for (int i = 0; i < NR; i++) if (!req_v[i]) rand_req(i);
    tick(); tick();
    rst_n = 1'b1;
    ptr = 0;
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    serve(0, 0, 0);
    req_v = '0;
    tick();

`ifdef FP_SCHED_STICKY_FLAGS_EN
    set_req(2, -1.0, -2.0, 1'b0);
    serve(rr_pick(), 0, 0);
    chk("sticky_of_set", 64'(sticky_of), 64'(4'b0100));
    set_req(2, 1.0, 2.0, 1'b0);
    serve(rr_pick(), 0, 0);
    chk("sticky_of_persist", 64'(sticky_of), 64'(4'b0100));
    set_req(1, 5.0, 5.0, 1'b1);
    serve(rr_pick(), 0, 0);
    chk("sticky_uf_set", 64'(sticky_uf), 64'(4'b0010));
    clr_mask = 4'b0100;
    set_req(2, -3.0, -4.0, 1'b1);
    serve(rr_pick(), 0, 0);
    clr_mask = '0;
    chk("sticky_set_wins", 64'(sticky_of), 64'(4'b0100));
    sticky_clr = 4'b0100;
    tick();
    sticky_clr = '0;
    chk("sticky_of_clr", 64'(sticky_of), 64'(0));
    chk("sticky_uf_kept", 64'(sticky_uf), 64'(4'b0010));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
